life_gen_sequencer: RTL and testbench

// - Steps the 16x16 Game-of-Life map one generation per accepted step request.
// - Scans all 256 cells sequentially (one per clk) and applies the B3/S23 rule on a torus.
// - Arbitrates map access between stepping and cursor edits (cell toggles from btn_out[4]).
// - Sits between the debounced button/cursor logic, the counter_1s tick, and the map consumers (display/VGA).

---
 rtl/life_gen_sequencer_pkg.sv | 23 ++
 rtl/life_gen_sequencer_cell_rule.sv | 36 +++
 rtl/life_gen_sequencer.sv | 144 ++++++++++++++
 tb/tb_life_gen_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_gen_sequencer_pkg.sv
// Shared grid geometry, FSM state encoding and cell indexing helper
// for the Game-of-Life generation sequencer.
package life_pkg;

    localparam int unsigned GRID_BITS = 4;
    localparam int unsigned GRID_SIDE = 16;
    localparam int unsigned CELLS     = 256;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned POP_W     = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Linear cell index: row-major, bit y*16+x.
    function automatic logic [IDX_W-1:0] idx(input logic [GRID_BITS-1:0] x,
                                             input logic [GRID_BITS-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/life_gen_sequencer_cell_rule.sv
// Combinational B3/S23 rule for one cell of the 16x16 torus: gathers the
// eight wrapped neighbours and returns the live-neighbour count and next state.
module life_cell_rule
    import life_pkg::CELLS;
    import life_pkg::IDX_W;
    import life_pkg::GRID_BITS;
(
    input  logic [CELLS-1:0] map,
    input  logic [IDX_W-1:0] idx,
    output logic             next_alive,
    output logic [3:0]       n
);

    logic [GRID_BITS-1:0] x;
    logic [GRID_BITS-1:0] y;
    logic [GRID_BITS-1:0] xm;
    logic [GRID_BITS-1:0] xp;
    logic [GRID_BITS-1:0] ym;
    logic [GRID_BITS-1:0] yp;

    // 4-bit wraparound gives the torus edges for free.
    assign x  = idx[GRID_BITS-1:0];
    assign y  = idx[IDX_W-1:GRID_BITS];
    assign xm = x - GRID_BITS'(1);
    assign xp = x + GRID_BITS'(1);
    assign ym = y - GRID_BITS'(1);
    assign yp = y + GRID_BITS'(1);

    always_comb begin
        n = 4'(map[{ym, xm}]) + 4'(map[{ym, x}]) + 4'(map[{ym, xp}])
          + 4'(map[{y,  xm}])                    + 4'(map[{y,  xp}])
          + 4'(map[{yp, xm}]) + 4'(map[{yp, x}]) + 4'(map[{yp, xp}]);
        next_alive = (n == 4'd3) | (map[idx] & (n == 4'd2));
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Steps the 16x16 Life map one generation per accepted request by scanning
// one cell per clock, and arbitrates cursor toggles against the scan.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int unsigned GEN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               run,
    input  logic               single_step,
    input  logic               clear,
    input  logic               edit_req,
    input  logic [3:0]         edit_x,
    input  logic [3:0]         edit_y,
    output logic [CELLS-1:0]   map,
    output logic               busy,
    output logic               edit_ack,
    output logic               tick_drop,
    output logic [GEN_W-1:0]   gen_count,
    output logic [POP_W-1:0]   alive_count
);

    state_e           state;
    logic [IDX_W-1:0] scan_idx;
    logic [CELLS-1:0] next_map;
    logic [POP_W-1:0] pop_acc;
    logic             pend_v;
    logic [IDX_W-1:0] pend_idx;

    logic             start_c;
    logic [IDX_W-1:0] edit_idx_c;
    logic             rule_alive;
    logic [3:0]       rule_n;
    logic             unused_n;
    logic             commit_edit_v_c;
    logic [IDX_W-1:0] commit_idx_c;
    logic [CELLS-1:0] commit_mask_c;
    logic [POP_W-1:0] commit_pop_c;

    assign start_c    = (run & tick) | single_step;
    assign edit_idx_c = idx(edit_x, edit_y);
    assign unused_n   = ^rule_n;

    life_cell_rule u_rule (
        .map        (map),
        .idx        (scan_idx),
        .next_alive (rule_alive),
        .n          (rule_n)
    );

    // An edit arriving on the COMMIT edge with an empty slot is folded into that commit.
    always_comb begin
        commit_edit_v_c = pend_v | edit_req;
        commit_idx_c    = pend_v ? pend_idx : edit_idx_c;
        commit_mask_c   = commit_edit_v_c ? (CELLS'(1) << commit_idx_c) : '0;
        commit_pop_c    = pop_acc;
        if (commit_edit_v_c) begin
            commit_pop_c = next_map[commit_idx_c] ? pop_acc - POP_W'(1)
                                                  : pop_acc + POP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scan_idx    <= '0;
            map         <= '0;
            next_map    <= '0;
            pop_acc     <= '0;
            pend_v      <= 1'b0;
            pend_idx    <= '0;
            gen_count   <= '0;
            alive_count <= '0;
            busy        <= 1'b0;
            edit_ack    <= 1'b0;
            tick_drop   <= 1'b0;
        end else begin
            edit_ack  <= 1'b0;
            tick_drop <= 1'b0;
            if (clear) begin
                state       <= IDLE;
                scan_idx    <= '0;
                map         <= '0;
                next_map    <= '0;
                pop_acc     <= '0;
                pend_v      <= 1'b0;
                gen_count   <= '0;
                alive_count <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (edit_req) begin
                            map[edit_idx_c] <= ~map[edit_idx_c];
                            alive_count     <= map[edit_idx_c] ? alive_count - POP_W'(1)
                                                               : alive_count + POP_W'(1);
                            edit_ack        <= 1'b1;
                        end
                        if (start_c) begin
                            state    <= SCAN;
                            scan_idx <= '0;
                            pop_acc  <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    SCAN: begin
                        next_map[scan_idx] <= rule_alive;
                        pop_acc            <= pop_acc + POP_W'(rule_alive);
                        if (edit_req && !pend_v) begin
                            pend_v   <= 1'b1;
                            pend_idx <= edit_idx_c;
                        end
                        if (start_c) begin
                            tick_drop <= 1'b1;
                        end
                        scan_idx <= scan_idx + IDX_W'(1);
                        if (scan_idx == IDX_W'(CELLS - 1)) begin
                            state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        map         <= next_map ^ commit_mask_c;
                        alive_count <= commit_pop_c;
                        gen_count   <= gen_count + GEN_W'(1);
                        edit_ack    <= commit_edit_v_c;
                        pend_v      <= 1'b0;
                        if (start_c) begin
                            tick_drop <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Randomized and directed bench for life_gen_sequencer against a
// generation-level Life model with a cycles-until-commit timer.
module tb_life_gen_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic         run;
    logic         single_step;
    logic         clear;
    logic         edit_req;
    logic [3:0]   edit_x;
    logic [3:0]   edit_y;
    logic [255:0] map;
    logic         busy;
    logic         edit_ack;
    logic         tick_drop;
    logic [15:0]  gen_count;
    logic [8:0]   alive_count;

    always #5 clk = ~clk;

    life_gen_sequencer #(.GEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .run         (run),
        .single_step (single_step),
        .clear       (clear),
        .edit_req    (edit_req),
        .edit_x      (edit_x),
        .edit_y      (edit_y),
        .map         (map),
        .busy        (busy),
        .edit_ack    (edit_ack),
        .tick_drop   (tick_drop),
        .gen_count   (gen_count),
        .alive_count (alive_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [255:0] m_map;
    int           m_timer;
    bit           m_pv;
    int           m_pi;
    logic [15:0]  m_gen;
    bit           m_ack;
    bit           m_drop;
    bit           run_lvl;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One Life generation on the 16x16 torus, straight from the rules.
    function automatic logic [255:0] life_next(input logic [255:0] cur);
        logic [255:0] nxt;
        nxt = '0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                int cnt;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            if (cur[((y + dy + 16) % 16) * 16 + (x + dx + 16) % 16]) cnt++;
                        end
                    end
                end
                nxt[y * 16 + x] = (cnt == 3) || (cur[y * 16 + x] && cnt == 2);
            end
        end
        return nxt;
    endfunction

    task automatic drive(input bit r, input bit t, input bit rn, input bit ss,
                         input bit cl, input bit er, input int x, input int y);
        bit start;
        int ei;
        @(negedge clk);
        rst = r; tick = t; run = rn; single_step = ss; clear = cl;
        edit_req = er; edit_x = 4'(x); edit_y = 4'(y);
        start  = (rn && t) || ss;
        ei     = y * 16 + x;
        m_ack  = 1'b0;
        m_drop = 1'b0;
        if (r || cl) begin
            m_map = '0; m_timer = 0; m_pv = 1'b0; m_gen = '0;
        end else if (m_timer == 0) begin
            if (er) begin
                m_map[ei] = ~m_map[ei];
                m_ack = 1'b1;
            end
            if (start) m_timer = 257;
        end else begin
            if (er && !m_pv) begin
                m_pv = 1'b1;
                m_pi = ei;
            end
            if (start) m_drop = 1'b1;
            m_timer--;
            if (m_timer == 0) begin
                m_map = life_next(m_map);
                if (m_pv) begin
                    m_map[m_pi] = ~m_map[m_pi];
                    m_ack = 1'b1;
                end
                m_pv  = 1'b0;
                m_gen = m_gen + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        check_val("map",         map,               m_map);
        check_val("busy",        256'(busy),        256'(m_timer != 0));
        check_val("edit_ack",    256'(edit_ack),    256'(m_ack));
        check_val("tick_drop",   256'(tick_drop),   256'(m_drop));
        check_val("gen_count",   256'(gen_count),   256'(m_gen));
        check_val("alive_count", 256'(alive_count), 256'($countones(m_map)));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive(1'b0, 1'b0, run_lvl, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic edit(input int x, input int y);
        drive(1'b0, 1'b0, run_lvl, 1'b0, 1'b0, 1'b1, x, y);
    endtask

    task automatic step_req();
        drive(1'b0, 1'b0, run_lvl, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        logic [255:0] exp;
        logic [255:0] pre;
        logic [15:0]  g0;
        rst = 1'b1; tick = 1'b0; run = 1'b0; single_step = 1'b0; clear = 1'b0;
        edit_req = 1'b0; edit_x = '0; edit_y = '0;
        m_map = '0; m_timer = 0; m_pv = 1'b0; m_pi = 0; m_gen = '0;
        m_ack = 1'b0; m_drop = 1'b0; run_lvl = 1'b0;

        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("reset_map", map, 256'd0);
        check_val("reset_gen", 256'(gen_count), 256'd0);

        // Blinker: vertical -> horizontal
        edit(7, 6); edit(7, 7); edit(7, 8);
        step_req();
        idle(257);
        exp = '0; exp[7 * 16 + 6] = 1'b1; exp[7 * 16 + 7] = 1'b1; exp[7 * 16 + 8] = 1'b1;
        check_val("blinker_map", map, exp);
        check_val("blinker_gen", 256'(gen_count), 256'd1);
        check_val("blinker_alive", 256'(alive_count), 256'd3);

        // Torus corner birth
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        edit(0, 0); edit(15, 0); edit(0, 15);
        step_req();
        idle(257);
        exp = '0; exp[0] = 1'b1; exp[15] = 1'b1; exp[240] = 1'b1; exp[255] = 1'b1;
        check_val("torus_map", map, exp);
        check_val("torus_alive", 256'(alive_count), 256'd4);
        check_val("torus_gen", 256'(gen_count), 256'd1);

        // Edit during SCAN lands at COMMIT
        edit(5, 5); edit(6, 5); edit(5, 6);
        pre = m_map;
        step_req();
        idle(10);
        edit(3, 3);
        check_val("scan_edit_hold", map, pre);
        idle(246);
        exp = life_next(pre); exp[51] = ~exp[51];
        check_val("scan_edit_map", map, exp);
        check_val("scan_edit_ack", 256'(edit_ack), 256'd1);

        // Overrun: tick while busy is dropped
        run_lvl = 1'b1;
        g0 = m_gen;
        step_req();
        idle(100);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("overrun_drop", 256'(tick_drop), 256'd1);
        idle(200);
        check_val("overrun_gen", 256'(gen_count), 256'(g0 + 16'd1));
        run_lvl = 1'b0;

        // Clear mid-SCAN with pending edit
        step_req();
        idle(20);
        edit(2, 2);
        idle(20);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check_val("clear_map", map, 256'd0);
        check_val("clear_busy", 256'(busy), 256'd0);
        idle(300);
        check_val("clear_gen", 256'(gen_count), 256'd0);

        // Randomized traffic
        for (int i = 0; i < 12000; i++) begin
            bit r, t, ss, cl, er;
            if ($urandom_range(0, 599) == 0) run_lvl = ~run_lvl;
            r  = ($urandom_range(0, 4999) == 0);
            cl = ($urandom_range(0, 2999) == 0);
            er = ($urandom_range(0, 2) == 0);
            ss = ($urandom_range(0, 399) == 0);
            t  = ($urandom_range(0, 79) == 0);
            drive(r, t, run_lvl, ss, cl, er, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
